player_input_ctrl: RTL and testbench
====================================

// Module: player_input_ctrl
// PURPOSE
//  Per-frame command sequencer between keycode selection and the two character motion blocks.
//  - Snapshots keycode_girl/keycode_boy once per frame.
//  - Drives held left/right move levels.
//  - Turns the "up" key into a jump request/acknowledge handshake per player, with air and cooldown gating.
//  - Two identical per-player FSMs share one frame-tick generator.
// PARAMETERS
//  COOLDOWN_FRAMES  2   frames spent in COOLDOWN after landing (0 = skip COOLDOWN)
//  REQ_TIMEOUT      4   frames JUMP_REQ may wait for ack before aborting to GROUND (>=1)
//  BUF_FRAMES       6   frames a buffered jump stays valid (JUMP_BUFFER_EN only)
// PORTS
//  Clk            in   1   system clock (50 MHz)
//  Reset          in   1   asynchronous, active-high reset
//  frame_clk      in   1   VGA vsync-rate strobe, asynchronous to Clk
//  keycode_girl   in   16  [15:8]=8'h1A up or 0; [7:0]=8'h04 left, 8'h07 right or 0
//  keycode_boy    in   16  [15:8]=8'h60 up or 0; [7:0]=8'h5C left, 8'h5E right or 0
//  girl_jump_ack  in   1   girl motion block accepted the jump (1-Clk pulse)
//  boy_jump_ack   in   1   boy motion block accepted the jump (1-Clk pulse)
//  girl_landed    in   1   girl on floor (level)
//  boy_landed     in   1   boy on floor (level)
//  girl_move_l/r  out  1   held move levels, girl
//  boy_move_l/r   out  1   held move levels, boy
//  girl_jump_req  out  1   jump request, held until ack or timeout
//  boy_jump_req   out  1   jump request, held until ack or timeout
//  girl_state     out  2   FSM state, debug/sprite select
//  boy_state      out  2   FSM state, debug/sprite select
// BEHAVIOUR
//  - Reset: all outputs 0, states GROUND, snapshots/counters/flags 0; takes effect immediately, also mid-handshake.
//  - frame_clk: 2-flop synchroniser + rising-edge detect -> frame_tick, one Clk wide, 3-Clk latency.
//  - Snapshot: on frame_tick register up/left/right per player by exact code compare; any other value reads 0.
//    prev_up holds the previous frame's up; up_edge = up & ~prev_up.
//  - Move outputs: registered in the Clk after frame_tick; move_l = left & ~right, move_r = right & ~left.
//    Updated in every state.
//  - States per player: GROUND=0, JUMP_REQ=1, AIR=2, COOLDOWN=3.
//  - GROUND: at frame_tick with up_edge -> JUMP_REQ; jump_req rises the next Clk.
//    A held key (no edge) never re-triggers.
//  - JUMP_REQ:
//    - jump_req=1.
//    - jump_ack -> AIR, jump_req=0 the next Clk.
//    - Timeout counter counts frame_ticks; reaching REQ_TIMEOUT -> GROUND, req=0.
//    - ack and timeout tick in the same Clk: ack wins.
//    - landed ignored.
//  - AIR: at frame_tick with landed=1 -> COOLDOWN (or GROUND if COOLDOWN_FRAMES==0).
//    Landing is sampled only on frame_tick.
//  - COOLDOWN: counter loads COOLDOWN_FRAMES on entry, decrements per frame_tick; at 0 -> GROUND.
//  - Stray jump_ack outside JUMP_REQ is ignored.
//  - Players fully independent; both may request in the same frame.
// CONFIGURATION
//  JUMP_BUFFER_EN defined:
//    - up_edge in AIR or COOLDOWN sets buf_valid and loads buf_age=BUF_FRAMES.
//    - buf_age decrements per frame_tick; at 0 buf_valid clears.
//    - In GROUND at frame_tick, buf_valid -> JUMP_REQ even without an edge, and clears buf_valid.
//    - A new edge re-arms buf_age.
//  JUMP_BUFFER_EN undefined: edges outside GROUND are discarded; no buffer logic synthesised.
// STRUCTURE
//  Package player_input_pkg:
//    - Key codes KC_GIRL_UP/LEFT/RIGHT, KC_BOY_UP/LEFT/RIGHT.
//    - typedef enum logic [1:0] pstate_t.
//    - Counter width constant FRAME_CNT_W=4.
//  Sub-module player_cmd_fsm instantiated twice with the player's decoded up/left/right.
//  Top level holds the synchroniser and the snapshot registers.
// TESTING
//  1. Reset during JUMP_REQ: all outputs 0 and state 0 asynchronously, before the next Clk edge.
//  2. keycode_girl=16'h1A04 for 3 frames, ack 5 Clk after req:
//     - move_l=1 throughout.
//     - Exactly one req pulse, released 1 Clk after ack.
//     - State 1->2.
//  3. keycode_boy=16'h6000, no ack: req held, drops after 4 frame_ticks, state back to 0, no re-request while held.
//  4. AIR, boy_landed=1 at a tick:
//     - state 3 for 2 ticks, then 0.
//     - up edge during COOLDOWN ignored (buffer off).
//     - With JUMP_BUFFER_EN: that edge gives JUMP_REQ on the first GROUND tick.
//  5. Both players press up in the same frame: both reqs assert the same Clk; acks arriving 1 Clk apart are handled independently.
//  6. keycode_girl=16'h0099 (unknown code): no move, no req.

Source files
------------

// File: rtl/player_input_pkg.sv
// Shared key codes, per-player state encoding and counter width for the player input controller.
package player_input_pkg;

    localparam logic [7:0] KC_GIRL_UP    = 8'h1A;
    localparam logic [7:0] KC_GIRL_LEFT  = 8'h04;
    localparam logic [7:0] KC_GIRL_RIGHT = 8'h07;
    localparam logic [7:0] KC_BOY_UP     = 8'h60;
    localparam logic [7:0] KC_BOY_LEFT   = 8'h5C;
    localparam logic [7:0] KC_BOY_RIGHT  = 8'h5E;

    localparam int FRAME_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_GROUND   = 2'd0,
        ST_JUMP_REQ = 2'd1,
        ST_AIR      = 2'd2,
        ST_COOLDOWN = 2'd3
    } pstate_t;

endpackage

// File: rtl/player_cmd_fsm.sv
// Per-player command FSM: held move levels plus jump request/ack handshake with air and cooldown gating.
// Optional jump buffering in AIR/COOLDOWN is built when JUMP_BUFFER_EN is defined.
module player_cmd_fsm
    import player_input_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 2,
    parameter int REQ_TIMEOUT     = 4
`ifdef JUMP_BUFFER_EN
    ,
    parameter int BUF_FRAMES      = 6
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       up_edge_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       jump_ack_i,
    input  logic       landed_i,
    output logic       move_l_o,
    output logic       move_r_o,
    output logic       jump_req_o,
    output logic [1:0] state_o
);

    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);
    localparam logic [FRAME_CNT_W-1:0] CD_LOAD = FRAME_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] TO_LAST = FRAME_CNT_W'(REQ_TIMEOUT - 1);

    pstate_t                state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   move_l_q, move_r_q;
    logic                   buf_hit;

`ifdef JUMP_BUFFER_EN
    localparam logic [FRAME_CNT_W-1:0] BUF_LOAD = FRAME_CNT_W'(BUF_FRAMES);

    logic                   buf_valid_q, buf_valid_d;
    logic [FRAME_CNT_W-1:0] buf_age_q, buf_age_d;

    assign buf_hit = buf_valid_q;

    // A buffered press is consumed by the first GROUND tick; edges in AIR/COOLDOWN (re)arm it.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_age_d   = buf_age_q;
        if (tick_i) begin
            if (state_q == ST_GROUND) begin
                buf_valid_d = 1'b0;
                buf_age_d   = '0;
            end else if (up_edge_i && (state_q == ST_AIR || state_q == ST_COOLDOWN)) begin
                buf_valid_d = 1'b1;
                buf_age_d   = BUF_LOAD;
            end else if (buf_valid_q) begin
                if (buf_age_q <= CNT_ONE) begin
                    buf_valid_d = 1'b0;
                    buf_age_d   = '0;
                end else begin
                    buf_age_d = buf_age_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_age_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_age_q   <= buf_age_d;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_GROUND: begin
                if (tick_i && (up_edge_i || buf_hit)) begin
                    state_d = ST_JUMP_REQ;
                    cnt_d   = '0;
                end
            end
            ST_JUMP_REQ: begin
                // Ack takes priority over a timeout tick in the same cycle.
                if (jump_ack_i) begin
                    state_d = ST_AIR;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == TO_LAST) begin
                        state_d = ST_GROUND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_AIR: begin
                if (tick_i && landed_i) begin
                    if (COOLDOWN_FRAMES == 0) begin
                        state_d = ST_GROUND;
                    end else begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = CD_LOAD;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick_i) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_GROUND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_GROUND;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_GROUND;
            cnt_q    <= '0;
            move_l_q <= 1'b0;
            move_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (tick_i) begin
                move_l_q <= left_i & ~right_i;
                move_r_q <= right_i & ~left_i;
            end
        end
    end

    assign move_l_o   = move_l_q;
    assign move_r_o   = move_r_q;
    assign jump_req_o = (state_q == ST_JUMP_REQ);
    assign state_o    = state_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Frame-synchronous keycode snapshot and per-player command sequencing for girl and boy.
// Define JUMP_BUFFER_EN to build jump buffering into both player FSMs.
module player_input_ctrl
    import player_input_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 2,
    parameter int REQ_TIMEOUT     = 4,
    parameter int BUF_FRAMES      = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode_girl,
    input  logic [15:0] keycode_boy,
    input  logic        girl_jump_ack,
    input  logic        boy_jump_ack,
    input  logic        girl_landed,
    input  logic        boy_landed,
    output logic        girl_move_l,
    output logic        girl_move_r,
    output logic        boy_move_l,
    output logic        boy_move_r,
    output logic        girl_jump_req,
    output logic        boy_jump_req,
    output logic [1:0]  girl_state,
    output logic [1:0]  boy_state
);

    logic fc_s1_q, fc_s2_q, fc_s3_q;
    logic frame_tick_q;
    logic snap_tick_q;

    logic g_up_q, g_prev_up_q, g_left_q, g_right_q;
    logic b_up_q, b_prev_up_q, b_left_q, b_right_q;

    // Two sync flops, then a registered rising edge: tick is one Clk wide, three Clk after frame_clk.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_s1_q      <= 1'b0;
            fc_s2_q      <= 1'b0;
            fc_s3_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            snap_tick_q  <= 1'b0;
        end else begin
            fc_s1_q      <= frame_clk;
            fc_s2_q      <= fc_s1_q;
            fc_s3_q      <= fc_s2_q;
            frame_tick_q <= fc_s2_q & ~fc_s3_q;
            snap_tick_q  <= frame_tick_q;
        end
    end

    // Snapshots load on the tick; the FSMs act one Clk later on the fresh values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            g_up_q      <= 1'b0;
            g_prev_up_q <= 1'b0;
            g_left_q    <= 1'b0;
            g_right_q   <= 1'b0;
            b_up_q      <= 1'b0;
            b_prev_up_q <= 1'b0;
            b_left_q    <= 1'b0;
            b_right_q   <= 1'b0;
        end else if (frame_tick_q) begin
            g_prev_up_q <= g_up_q;
            g_up_q      <= (keycode_girl[15:8] == KC_GIRL_UP);
            g_left_q    <= (keycode_girl[7:0] == KC_GIRL_LEFT);
            g_right_q   <= (keycode_girl[7:0] == KC_GIRL_RIGHT);
            b_prev_up_q <= b_up_q;
            b_up_q      <= (keycode_boy[15:8] == KC_BOY_UP);
            b_left_q    <= (keycode_boy[7:0] == KC_BOY_LEFT);
            b_right_q   <= (keycode_boy[7:0] == KC_BOY_RIGHT);
        end
    end

    player_cmd_fsm #(
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .REQ_TIMEOUT    (REQ_TIMEOUT)
`ifdef JUMP_BUFFER_EN
        ,
        .BUF_FRAMES     (BUF_FRAMES)
`endif
    ) u_girl (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .tick_i    (snap_tick_q),
        .up_edge_i (g_up_q & ~g_prev_up_q),
        .left_i    (g_left_q),
        .right_i   (g_right_q),
        .jump_ack_i(girl_jump_ack),
        .landed_i  (girl_landed),
        .move_l_o  (girl_move_l),
        .move_r_o  (girl_move_r),
        .jump_req_o(girl_jump_req),
        .state_o   (girl_state)
    );

    player_cmd_fsm #(
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .REQ_TIMEOUT    (REQ_TIMEOUT)
`ifdef JUMP_BUFFER_EN
        ,
        .BUF_FRAMES     (BUF_FRAMES)
`endif
    ) u_boy (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .tick_i    (snap_tick_q),
        .up_edge_i (b_up_q & ~b_prev_up_q),
        .left_i    (b_left_q),
        .right_i   (b_right_q),
        .jump_ack_i(boy_jump_ack),
        .landed_i  (boy_landed),
        .move_l_o  (boy_move_l),
        .move_r_o  (boy_move_r),
        .jump_req_o(boy_jump_req),
        .state_o   (boy_state)
    );

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with immediate-assertion checks (default parameters).
// Test 4 expectations follow JUMP_BUFFER_EN when the build defines it.
module tb_player_input_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode_girl, keycode_boy;
    logic        girl_jump_ack, boy_jump_ack;
    logic        girl_landed, boy_landed;
    logic        girl_move_l, girl_move_r, boy_move_l, boy_move_r;
    logic        girl_jump_req, boy_jump_req;
    logic [1:0]  girl_state, boy_state;

    int checks = 0;
    int errors = 0;

    int     g_rises = 0, b_rises = 0;
    logic   g_req_prev = 1'b0, b_req_prev = 1'b0;
    longint g_rise_t = 0, b_rise_t = 0;
    int     base_g, base_b;

    player_input_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode_girl (keycode_girl),
        .keycode_boy  (keycode_boy),
        .girl_jump_ack(girl_jump_ack),
        .boy_jump_ack (boy_jump_ack),
        .girl_landed  (girl_landed),
        .boy_landed   (boy_landed),
        .girl_move_l  (girl_move_l),
        .girl_move_r  (girl_move_r),
        .boy_move_l   (boy_move_l),
        .boy_move_r   (boy_move_r),
        .girl_jump_req(girl_jump_req),
        .boy_jump_req (boy_jump_req),
        .girl_state   (girl_state),
        .boy_state    (boy_state)
    );

    always #5 Clk = ~Clk;

    // Request rise counter / timestamp, sampled on the inactive edge.
    always @(negedge Clk) begin
        if (girl_jump_req && !g_req_prev) begin
            g_rises  = g_rises + 1;
            g_rise_t = $time;
        end
        if (boy_jump_req && !b_req_prev) begin
            b_rises  = b_rises + 1;
            b_rise_t = $time;
        end
        g_req_prev = girl_jump_req;
        b_req_prev = boy_jump_req;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: frame_clk high 4 Clk, low 4 Clk; all processing of the tick finishes inside.
    task automatic do_frame();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic ack_girl();
        girl_jump_ack = 1'b1;
        @(negedge Clk);
        girl_jump_ack = 1'b0;
    endtask

    task automatic ack_boy();
        boy_jump_ack = 1'b1;
        @(negedge Clk);
        boy_jump_ack = 1'b0;
    endtask

    initial begin
        Reset         = 1'b1;
        frame_clk     = 1'b0;
        keycode_girl  = 16'h0000;
        keycode_boy   = 16'h0000;
        girl_jump_ack = 1'b0;
        boy_jump_ack  = 1'b0;
        girl_landed   = 1'b0;
        boy_landed    = 1'b0;
        repeat (3) @(negedge Clk);

        check("rst_girl_state", 8'(girl_state), 8'd0);
        check("rst_boy_state", 8'(boy_state), 8'd0);
        check("rst_girl_req", 8'(girl_jump_req), 8'd0);
        check("rst_boy_req", 8'(boy_jump_req), 8'd0);
        check("rst_moves", 8'({girl_move_l, girl_move_r, boy_move_l, boy_move_r}), 8'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Test 1: reset asserted mid-handshake clears outputs before the next Clk edge.
        keycode_girl = 16'h1A04;
        do_frame();
        check("t1_state_req", 8'(girl_state), 8'd1);
        check("t1_req_high", 8'(girl_jump_req), 8'd1);
        check("t1_move_l", 8'(girl_move_l), 8'd1);
        #2 Reset = 1'b1;
        #1;
        check("t1_async_req", 8'(girl_jump_req), 8'd0);
        check("t1_async_state", 8'(girl_state), 8'd0);
        check("t1_async_move", 8'(girl_move_l), 8'd0);
        @(negedge Clk);
        Reset = 1'b0;
        keycode_girl = 16'h0000;
        @(negedge Clk);
        do_frame();

        // Test 2: girl up+left held 3 frames, single request, ack releases it.
        base_g = g_rises;
        keycode_girl = 16'h1A04;
        do_frame();
        check("t2_move_l_f1", 8'(girl_move_l), 8'd1);
        check("t2_state_f1", 8'(girl_state), 8'd1);
        @(negedge Clk);
        check("t2_req_before_ack", 8'(girl_jump_req), 8'd1);
        ack_girl();
        check("t2_req_after_ack", 8'(girl_jump_req), 8'd0);
        check("t2_state_air", 8'(girl_state), 8'd2);
        do_frame();
        check("t2_move_l_f2", 8'(girl_move_l), 8'd1);
        do_frame();
        check("t2_move_l_f3", 8'(girl_move_l), 8'd1);
        check("t2_state_f3", 8'(girl_state), 8'd2);
        check("t2_one_pulse", 8'(g_rises - base_g), 8'd1);
        check("t2_move_r", 8'(girl_move_r), 8'd0);

        // Test 3: boy up with no ack times out after 4 more ticks; held key does not retrigger.
        base_b = b_rises;
        keycode_boy = 16'h6000;
        do_frame();
        check("t3_req_f1", 8'(boy_jump_req), 8'd1);
        do_frame();
        do_frame();
        do_frame();
        check("t3_req_f4", 8'(boy_jump_req), 8'd1);
        check("t3_state_f4", 8'(boy_state), 8'd1);
        do_frame();
        check("t3_req_timeout", 8'(boy_jump_req), 8'd0);
        check("t3_state_timeout", 8'(boy_state), 8'd0);
        do_frame();
        do_frame();
        check("t3_no_rereq_state", 8'(boy_state), 8'd0);
        check("t3_one_pulse", 8'(b_rises - base_b), 8'd1);

        // Test 4: boy lands, cooldown 2 ticks, up edge during cooldown.
        keycode_girl = 16'h0000;
        keycode_boy  = 16'h0000;
        do_reset();
        do_frame();
        keycode_boy = 16'h6000;
        do_frame();
        check("t4_req", 8'(boy_state), 8'd1);
        ack_boy();
        check("t4_air", 8'(boy_state), 8'd2);
        keycode_boy = 16'h0000;
        do_frame();
        check("t4_air_hold", 8'(boy_state), 8'd2);
        boy_landed = 1'b1;
        do_frame();
        check("t4_cooldown_1", 8'(boy_state), 8'd3);
        keycode_boy = 16'h6000;
        do_frame();
        check("t4_cooldown_2", 8'(boy_state), 8'd3);
        check("t4_cd_no_req", 8'(boy_jump_req), 8'd0);
        do_frame();
        check("t4_ground", 8'(boy_state), 8'd0);
        do_frame();
`ifdef JUMP_BUFFER_EN
        check("t4_buffered_state", 8'(boy_state), 8'd1);
        check("t4_buffered_req", 8'(boy_jump_req), 8'd1);
`else
        check("t4_edge_dropped_state", 8'(boy_state), 8'd0);
        check("t4_edge_dropped_req", 8'(boy_jump_req), 8'd0);
`endif
        boy_landed = 1'b0;

        // Test 5: both players request together; acks one Clk apart.
        keycode_boy = 16'h0000;
        do_reset();
        do_frame();
        keycode_girl = 16'h1A00;
        keycode_boy  = 16'h6000;
        do_frame();
        check("t5_girl_req", 8'(girl_jump_req), 8'd1);
        check("t5_boy_req", 8'(boy_jump_req), 8'd1);
        check("t5_same_clk", 8'(g_rise_t == b_rise_t), 8'd1);
        ack_girl();
        check("t5_girl_released", 8'(girl_jump_req), 8'd0);
        check("t5_girl_air", 8'(girl_state), 8'd2);
        check("t5_boy_still_req", 8'(boy_jump_req), 8'd1);
        ack_boy();
        check("t5_boy_released", 8'(boy_jump_req), 8'd0);
        check("t5_boy_air", 8'(boy_state), 8'd2);
        check("t5_girl_air_kept", 8'(girl_state), 8'd2);

        // Test 6: unknown codes decode to nothing; right key and stray ack.
        keycode_girl = 16'h0000;
        keycode_boy  = 16'h0000;
        do_reset();
        keycode_girl = 16'h0099;
        do_frame();
        do_frame();
        check("t6_no_move", 8'({girl_move_l, girl_move_r}), 8'd0);
        check("t6_no_req", 8'(girl_jump_req), 8'd0);
        check("t6_state", 8'(girl_state), 8'd0);
        keycode_girl = 16'h0007;
        keycode_boy  = 16'h005C;
        do_frame();
        check("t6_girl_right", 8'({girl_move_l, girl_move_r}), 8'd1);
        check("t6_boy_left", 8'({boy_move_l, boy_move_r}), 8'd2);
        ack_girl();
        @(negedge Clk);
        check("t6_stray_ack", 8'(girl_state), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
